// File: rtl/vector_wb_arbiter.sv
// Writeback arbiter: merges NUM_INPUTS packetised result streams into one
// registered GPR write stream, round-robin between packets, atomic within one.
module vector_wb_arbiter #(
  parameter int NUM_INPUTS    = 4,
  parameter int NUM_THREADS   = 4,
  parameter int XLEN          = 32,
  parameter int NR_BITS       = 6,
  parameter int WIS_BITS      = 2,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_INPUTS-1:0]                valid_in,
  output logic [NUM_INPUTS-1:0]                ready_in,
  input  logic [NUM_INPUTS*WIS_BITS-1:0]       wis_in,
  input  logic [NUM_INPUTS*NUM_THREADS-1:0]    tmask_in,
  input  logic [NUM_INPUTS*NR_BITS-1:0]        rd_in,
  input  logic [NUM_INPUTS*NUM_THREADS*XLEN-1:0] data_in,
  input  logic [NUM_INPUTS-1:0]                sop_in,
  input  logic [NUM_INPUTS-1:0]                eop_in,
  output logic                                 wb_valid,
  output logic [WIS_BITS-1:0]                  wb_wis,
  output logic [NUM_THREADS-1:0]               wb_tmask,
  output logic [NR_BITS-1:0]                   wb_rd,
  output logic [NUM_THREADS*XLEN-1:0]          wb_data,
  output logic                                 wb_sop,
  output logic                                 wb_eop,
  output logic                                 proto_err,
  output logic [PERF_CTR_BITS-1:0]             perf_stalls
);

  localparam int IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int CNT_W  = $clog2(NUM_INPUTS + 1);
  localparam int BEAT_W = NUM_THREADS * XLEN;

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e             r_state, w_state_next;
  logic [IDX_W-1:0]   r_owner, r_rr_ptr;
  logic [IDX_W-1:0]   w_owner_next, w_rr_next, w_grant, w_sel;
  logic               w_grant_found, w_accept, w_err_set;
  logic               w_sel_sop, w_sel_eop;
  logic [NR_BITS-1:0] w_sel_rd;
  logic [CNT_W-1:0]   w_stall_cnt;
  logic [PERF_CTR_BITS:0] w_stall_sum;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(NUM_INPUTS - 1)) ? '0 : x + 1'b1;
  endfunction

  // First valid input at or after the round-robin pointer, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_grant       = r_rr_ptr;
    w_grant_found = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      int idx;
      idx = int'(r_rr_ptr) + i;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      if (!w_grant_found && valid_in[idx]) begin
        w_grant_found = 1'b1;
        w_grant       = IDX_W'(idx);
      end
    end
  end

  assign w_sel = (r_state == LOCKED) ? r_owner : w_grant;

  always_comb begin
    ready_in = '0;
    if (reset) begin
      if (r_state == LOCKED) ready_in[r_owner] = valid_in[r_owner];
      else if (w_grant_found) ready_in[w_grant] = 1'b1;
    end
  end

  assign w_accept  = |ready_in;
  assign w_sel_sop = sop_in[w_sel];
  assign w_sel_eop = eop_in[w_sel];
  assign w_sel_rd  = rd_in[int'(w_sel)*NR_BITS +: NR_BITS];

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_rr_next    = r_rr_ptr;
    w_err_set    = 1'b0;
    if (w_accept) begin
      if (r_state == UNLOCKED) begin
        w_err_set = !w_sel_sop;
        if (w_sel_eop) begin
          w_rr_next = wrap_inc(w_grant);
        end else begin
          w_state_next = LOCKED;
          w_owner_next = w_grant;
        end
      end else begin
        // sop+eop on the owner's last beat still closes the packet.
        w_err_set = w_sel_sop;
        if (w_sel_eop) begin
          w_state_next = UNLOCKED;
          w_rr_next    = wrap_inc(r_owner);
        end
      end
    end
  end

  always_comb begin
    w_stall_cnt = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      w_stall_cnt = w_stall_cnt + CNT_W'(valid_in[i] & ~ready_in[i]);
    w_stall_sum = {1'b0, perf_stalls} + (PERF_CTR_BITS+1)'(w_stall_cnt);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      r_state     <= UNLOCKED;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      wb_valid    <= 1'b0;
      wb_wis      <= '0;
      wb_tmask    <= '0;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_sop      <= 1'b0;
      wb_eop      <= 1'b0;
      proto_err   <= 1'b0;
      perf_stalls <= '0;
    end else begin
      r_state   <= w_state_next;
      r_owner   <= w_owner_next;
      r_rr_ptr  <= w_rr_next;
      proto_err <= proto_err | w_err_set;
      // Register-0 beats are consumed but never strobe the RAM.
      wb_valid  <= w_accept && (w_sel_rd != '0);
      if (w_accept) begin
        wb_wis   <= wis_in[int'(w_sel)*WIS_BITS +: WIS_BITS];
        wb_tmask <= tmask_in[int'(w_sel)*NUM_THREADS +: NUM_THREADS];
        wb_rd    <= w_sel_rd;
        wb_data  <= data_in[int'(w_sel)*BEAT_W +: BEAT_W];
        wb_sop   <= w_sel_sop;
        wb_eop   <= w_sel_eop;
      end
      perf_stalls <= w_stall_sum[PERF_CTR_BITS] ? {PERF_CTR_BITS{1'b1}}
                                                 : w_stall_sum[PERF_CTR_BITS-1:0];
    end
  end

endmodule

// File: tb/tb_vector_wb_arbiter.sv
// Directed bench for vector_wb_arbiter: packet-level reference model checked
// every cycle, plus literal expectations from the scenarios it walks through.
module tb_vector_wb_arbiter;

  localparam int N  = 4;
  localparam int T  = 4;
  localparam int X  = 32;
  localparam int NR = 6;
  localparam int WB = 2;
  localparam int PC = 44;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      valid_in = '0;
  logic [N-1:0]      ready_in;
  logic [N*WB-1:0]   wis_in = '0;
  logic [N*T-1:0]    tmask_in = '0;
  logic [N*NR-1:0]   rd_in = '0;
  logic [N*T*X-1:0]  data_in = '0;
  logic [N-1:0]      sop_in = '0;
  logic [N-1:0]      eop_in = '0;
  logic              wb_valid;
  logic [WB-1:0]     wb_wis;
  logic [T-1:0]      wb_tmask;
  logic [NR-1:0]     wb_rd;
  logic [T*X-1:0]    wb_data;
  logic              wb_sop, wb_eop, proto_err;
  logic [PC-1:0]     perf_stalls;

  vector_wb_arbiter #(
    .NUM_INPUTS(N), .NUM_THREADS(T), .XLEN(X),
    .NR_BITS(NR), .WIS_BITS(WB), .PERF_CTR_BITS(PC)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .wis_in(wis_in), .tmask_in(tmask_in), .rd_in(rd_in), .data_in(data_in),
    .sop_in(sop_in), .eop_in(eop_in), .wb_valid(wb_valid), .wb_wis(wb_wis),
    .wb_tmask(wb_tmask), .wb_rd(wb_rd), .wb_data(wb_data), .wb_sop(wb_sop),
    .wb_eop(wb_eop), .proto_err(proto_err), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- packet-level reference model ----------------
  bit           m_ok = 0, m_zero = 0, m_locked = 0, m_err = 0;
  int           m_owner = 0, m_rr = 0;
  longint       m_stalls = 0;
  bit           e_valid = 0, e_sop = 0, e_eop = 0;
  logic [WB-1:0]  e_wis = '0;
  logic [T-1:0]   e_tmask = '0;
  logic [NR-1:0]  e_rd = '0;
  logic [T*X-1:0] e_data = '0;

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    r = '0;
    if (!reset) return r;
    if (m_locked) begin
      r[m_owner] = valid_in[m_owner];
      return r;
    end
    for (int j = 0; j < N; j++) begin
      int k;
      k = (m_rr + j) % N;
      if (valid_in[k]) begin
        r[k] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] er;
    int idx;
    er = model_ready();
    if (reset || m_ok) check("ready_in", 128'(ready_in), 128'(er));
    if (m_ok) begin
      check("wb_valid", 128'(wb_valid), 128'(e_valid));
      check("proto_err", 128'(proto_err), 128'(m_err));
      check("perf_stalls", 128'(perf_stalls), 128'(m_stalls));
      if (e_valid || m_zero) begin
        check("wb_rd", 128'(wb_rd), 128'(e_rd));
        check("wb_wis", 128'(wb_wis), 128'(e_wis));
        check("wb_tmask", 128'(wb_tmask), 128'(e_tmask));
        check("wb_data", 128'(wb_data), 128'(e_data));
        check("wb_sop_eop", 128'({wb_sop, wb_eop}), 128'({e_sop, e_eop}));
      end
    end
    // Advance the model to what the coming rising edge must produce.
    if (!reset) begin
      m_ok = 1; m_zero = 1; m_locked = 0; m_err = 0; m_rr = 0; m_owner = 0;
      m_stalls = 0; e_valid = 0; e_sop = 0; e_eop = 0;
      e_wis = '0; e_tmask = '0; e_rd = '0; e_data = '0;
    end else begin
      m_stalls = m_stalls + $countones(valid_in & ~er);
      if (m_stalls > longint'({PC{1'b1}})) m_stalls = longint'({PC{1'b1}});
      e_valid = 0;
      if (er != '0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (er[i]) idx = i;
        m_zero  = 0;
        e_rd    = rd_in[idx*NR +: NR];
        e_wis   = wis_in[idx*WB +: WB];
        e_tmask = tmask_in[idx*T +: T];
        e_data  = data_in[idx*T*X +: T*X];
        e_sop   = sop_in[idx];
        e_eop   = eop_in[idx];
        e_valid = (e_rd != 0);
        if (!m_locked) begin
          if (!e_sop) m_err = 1;
          if (e_eop) m_rr = (idx + 1) % N;
          else begin m_locked = 1; m_owner = idx; end
        end else begin
          if (e_sop) m_err = 1;
          if (e_eop) begin m_locked = 0; m_rr = (m_owner + 1) % N; end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input bit v, input bit s, input bit e,
                        input logic [NR-1:0] rd, input logic [T-1:0] tm,
                        input logic [X-1:0] d);
    valid_in[i]             = v;
    sop_in[i]               = s;
    eop_in[i]               = e;
    rd_in[i*NR +: NR]       = rd;
    tmask_in[i*T +: T]      = tm;
    wis_in[i*WB +: WB]      = WB'(i);
    data_in[i*T*X +: T*X]   = {T{d}};
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_in(i, 0, 0, 0, '0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 0;
    clear_all();
    tick(); tick();
    @(negedge clk);
    check("rst_ready", 128'(ready_in), 128'(0));
    check("rst_wb_valid", 128'(wb_valid), 128'(0));
    check("rst_perf", 128'(perf_stalls), 128'(0));

    // Round-robin fairness: all inputs always offer single-beat packets.
    tick();
    reset = 1;
    for (int i = 0; i < N; i++) set_in(i, 1, 1, 1, NR'(i + 1), 4'hF, 32'(i));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_grant", 128'(ready_in), 128'(4'b0001 << (k % 4)));
      check("rr_stalls", 128'(perf_stalls), 128'(3 * k));
      if (k > 0) begin
        check("rr_wb_valid", 128'(wb_valid), 128'(1));
        check("rr_wb_rd", 128'(wb_rd), 128'(((k - 1) % 4) + 1));
      end
      tick();
    end
    clear_all();
    @(negedge clk);
    check("rr_last_rd", 128'(wb_rd), 128'(2));
    tick();

    // Packet atomicity: input 1 locks, input 2 waits its turn.
    set_in(1, 1, 1, 0, 6'd5, 4'hF, 32'h11);
    @(negedge clk);
    check("atom_lock_grant", 128'(ready_in), 128'(4'b0010));
    tick();
    set_in(1, 1, 0, 0, 6'd5, 4'hF, 32'h22);
    set_in(2, 1, 1, 1, 6'd9, 4'hF, 32'h44);
    @(negedge clk);
    check("atom_hold_b2", 128'(ready_in), 128'(4'b0010));
    check("atom_d1", 128'({wb_data[31:0], wb_sop, wb_eop}), 128'({32'h11, 2'b10}));
    tick();
    set_in(1, 1, 0, 1, 6'd5, 4'hF, 32'h33);
    @(negedge clk);
    check("atom_hold_b3", 128'(ready_in), 128'(4'b0010));
    check("atom_d2", 128'({wb_data[31:0], wb_sop, wb_eop}), 128'({32'h22, 2'b00}));
    tick();
    set_in(1, 0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check("atom_next_grant", 128'(ready_in), 128'(4'b0100));
    check("atom_d3", 128'({wb_data[31:0], wb_sop, wb_eop}), 128'({32'h33, 2'b01}));
    tick();
    set_in(2, 0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check("atom_in2_rd", 128'({wb_valid, wb_rd}), 128'({1'b1, 6'd9}));
    tick();

    // Owner gap while locked: input 3 must wait for input 0's eop.
    set_in(0, 1, 1, 0, 6'd10, 4'hF, 32'hA0);
    @(negedge clk);
    check("gap_lock_grant", 128'(ready_in), 128'(4'b0001));
    tick();
    set_in(0, 0, 0, 0, 6'd10, 4'hF, 32'hA0);
    set_in(3, 1, 1, 1, 6'd12, 4'hF, 32'hC0);
    @(negedge clk);
    check("gap_no_ready", 128'(ready_in), 128'(4'b0000));
    tick();
    set_in(0, 1, 0, 1, 6'd10, 4'hF, 32'hA1);
    @(negedge clk);
    check("gap_owner_eop", 128'(ready_in), 128'(4'b0001));
    check("gap_idle_wb", 128'(wb_valid), 128'(0));
    tick();
    set_in(0, 0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check("gap_in3_after", 128'(ready_in), 128'(4'b1000));
    tick();
    set_in(3, 0, 0, 0, '0, '0, '0);

    // Register-0 write, then rd=7, then an all-zero lane mask.
    set_in(0, 1, 1, 1, 6'd0, 4'hF, 32'h99);
    @(negedge clk);
    check("r0_ready", 128'(ready_in), 128'(4'b0001));
    tick();
    set_in(0, 1, 1, 1, 6'd7, 4'hF, 32'h77);
    @(negedge clk);
    check("r0_no_strobe", 128'(wb_valid), 128'(0));
    tick();
    set_in(0, 0, 0, 0, '0, '0, '0);
    set_in(1, 1, 1, 1, 6'd3, 4'h0, 32'h55);
    @(negedge clk);
    check("r7_strobe", 128'({wb_valid, wb_rd}), 128'({1'b1, 6'd7}));
    check("tm0_grant", 128'(ready_in), 128'(4'b0010));
    tick();
    set_in(1, 0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check("tm0_fwd", 128'({wb_valid, wb_tmask}), 128'({1'b1, 4'h0}));
    tick();

    // Protocol error inside a packet, then reset mid-packet.
    set_in(2, 1, 1, 0, 6'd20, 4'hF, 32'hE0);
    @(negedge clk);
    check("err_lock_grant", 128'(ready_in), 128'(4'b0100));
    tick();
    set_in(2, 1, 1, 0, 6'd20, 4'hF, 32'hE1);
    @(negedge clk);
    check("err_not_yet", 128'(proto_err), 128'(0));
    tick();
    set_in(2, 1, 0, 0, 6'd20, 4'hF, 32'hE2);
    @(negedge clk);
    check("err_flagged", 128'(proto_err), 128'(1));
    tick();
    reset = 0;
    set_in(0, 1, 1, 1, 6'd1, 4'hF, 32'h01);
    @(negedge clk);
    check("err_rst_ready", 128'(ready_in), 128'(0));
    tick();
    reset = 1;
    @(negedge clk);
    check("post_rst_err", 128'(proto_err), 128'(0));
    check("post_rst_wb", 128'({wb_valid, wb_rd, wb_data}), 128'(0));
    check("post_rst_grant", 128'(ready_in), 128'(4'b0001));
    tick();
    clear_all();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vector_wb_arbiter.md
Name: vector_wb_arbiter

Overview:
- Writer-side counterpart of the banked GPR operand collector: merges result streams from NUM_INPUTS execute units into the single writeback stream that writes the per-bank GPR RAMs.
- Results are packets of one or more beats, delimited by sop/eop. A multi-beat packet is never interleaved with another.
- The output is registered. It has no backpressure because the GPR write port always accepts, so all stalling is pushed back onto the inputs.

Parameters:
- NUM_INPUTS, 4, number of execute-unit result streams (≥1)
- NUM_THREADS, 4, lanes per beat
- XLEN, 32, bits per lane
- NR_BITS, 6, register index width
- WIS_BITS, 2, issue-warp index width (≥1)
- PERF_CTR_BITS, 44, stall counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- valid_in  in  NUM_INPUTS  beat valid per input
- ready_in  out  NUM_INPUTS  beat accepted per input
- wis_in  in  NUM_INPUTS*WIS_BITS  warp index per input
- tmask_in  in  NUM_INPUTS*NUM_THREADS  lane write mask per input
- rd_in  in  NUM_INPUTS*NR_BITS  destination register per input
- data_in  in  NUM_INPUTS*NUM_THREADS*XLEN  lane data per input
- sop_in  in  NUM_INPUTS  first beat of packet
- eop_in  in  NUM_INPUTS  last beat of packet
- wb_valid  out  1  GPR write strobe
- wb_wis  out  WIS_BITS  write warp
- wb_tmask  out  NUM_THREADS  write lane mask
- wb_rd  out  NR_BITS  write register
- wb_data  out  NUM_THREADS*XLEN  write data
- wb_sop  out  1  forwarded sop
- wb_eop  out  1  forwarded eop
- proto_err  out  1  sticky protocol violation flag
- perf_stalls  out  PERF_CTR_BITS  count of input-beat-cycles stalled

Behaviour:
- Reset (reset==0 at a clk edge):
  - all outputs go to 0;
  - state goes to UNLOCKED;
  - the round-robin pointer rr_ptr goes to 0;
  - proto_err and perf_stalls go to 0;
  - ready_in is 0 during reset.
- Reset applied mid-packet abandons the packet. After reset, arbitration restarts fresh with no memory of the owner.
- State UNLOCKED:
  - Grant goes to the first valid input searching from rr_ptr upward, wrapping modulo NUM_INPUTS.
  - ready_in is one-hot on the granted input (combinational from valid_in and state). It is 0 if no input is valid.
  - The accepted beat has sop==1 and eop==0: go to LOCKED(owner=granted).
  - The accepted beat has sop==1 and eop==1: stay UNLOCKED and set rr_ptr=(granted+1) mod NUM_INPUTS.
- State LOCKED(owner):
  - ready_in[owner]=valid_in[owner]; all other ready_in are 0.
  - Accepted beat with eop==1: go to UNLOCKED and set rr_ptr=(owner+1) mod NUM_INPUTS.
- Protocol errors set proto_err=1 (sticky until reset); the beat is still forwarded:
  - a beat accepted in UNLOCKED with sop==0;
  - a beat accepted in LOCKED with sop==1.
- Datapath:
  - An accepted beat is registered. wb_* reflect it exactly 1 cycle after acceptance.
  - wb_valid=1 for that cycle only, with no hold.
  - Throughput is one beat per cycle.
- Writes to register 0:
  - An accepted beat with rd_in==0 is consumed, but wb_valid stays 0 in the following cycle.
  - Lock/unlock and rr_ptr still follow its sop/eop.
- An accepted beat with tmask_in==0 is forwarded normally with wb_valid=1 and wb_tmask=0; the RAM byte-enables gate it.
- perf_stalls increments by popcount(valid_in & ~ready_in) each cycle, saturating at all-ones.
- Simultaneous sop and eop on the owner's final beat while LOCKED: treat as eop, unlock, and flag proto_err.
- NUM_INPUTS==1: grant is trivially input 0 and rr_ptr stays 0.

Test Plan:
- Round-robin fairness:
  - Stimulus: inputs 0..3 each hold single-beat packets (sop=eop=1) continuously, starting from reset.
  - Required: grants in order 0,1,2,3,0,…; wb_valid=1 every cycle from cycle 2; perf_stalls increases by 3 per cycle.
- Packet atomicity:
  - Stimulus: input 1 sends a 3-beat packet (rd=5, data 0x11/0x22/0x33) while input 2 holds a valid single beat.
  - Required: wb_data shows 0x11,0x22,0x33 on consecutive cycles with wb_sop=1,0,0 and wb_eop=0,0,1; input 2's beat appears next.
- Owner gaps while locked:
  - Stimulus: input 0 drops valid between beats 1 and 2 of its packet while input 3 is valid.
  - Required: ready_in[3] stays 0 until input 0's eop beat is accepted, then input 1..3 search begins at rr_ptr=1.
- Register 0 writes:
  - Stimulus: single beat with rd=0, tmask=4'b1111, followed by a single beat with rd=7.
  - Required: the first beat's ready_in is 1, wb_valid=0 in the following cycle; the next cycle shows wb_valid=1 with wb_rd=7.
- Protocol error and reset:
  - Stimulus: in LOCKED, the owner sends sop=1; then reset=0 is applied mid-packet.
  - Required: proto_err=1 the next cycle. After reset, proto_err=0, all wb_*=0, and input 0 is granted first.
